// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel threshold stage: FSM states,
// default image geometry, pixel widths and the 8-bit magnitude saturator.
package sobel_pkg;

  localparam int PIX_W          = 10;
  localparam int MAG_W          = 8;
  localparam int DEFAULT_SIZE_X = 640;
  localparam int DEFAULT_SIZE_Y = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Any bit above the low MAG_W bits means the value exceeds 255.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [PIX_W-1:0] v);
    return (|v[PIX_W-1:MAG_W]) ? {MAG_W{1'b1}} : v[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_threshold_if.sv
// Pixel-stream bus between the Sobel stage, the threshold block and its sink.
interface sobel_threshold_if #(
  parameter int CNT_W = 20
) ();

  logic                         control;
  logic                         fsync;
  logic [sobel_pkg::PIX_W-1:0]  pin;
  logic [sobel_pkg::MAG_W-1:0]  threshold;
  logic [sobel_pkg::PIX_W-1:0]  pout;
  logic                         pout_valid;
  logic [CNT_W-1:0]             edge_count;
  logic                         frame_done;

  modport master (
    output control, fsync, pin, threshold,
    input  pout, pout_valid, edge_count, frame_done
  );

  modport slave (
    input  control, fsync, pin, threshold,
    output pout, pout_valid, edge_count, frame_done
  );

endinterface

// File: rtl/sobel_pix_counter.sv
// Window-centre x/y coordinate counter with raster wrap, border and
// last-pixel flags for the beat currently being processed.
module sobel_pix_counter #(
  parameter int SIZE_X = sobel_pkg::DEFAULT_SIZE_X,
  parameter int SIZE_Y = sobel_pkg::DEFAULT_SIZE_Y
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic step_i,
  output logic border_o,
  output logic last_o
);

  localparam int XW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int YW = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;

  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          x_end, y_end;

  // A frame-sync beat is pixel (0,0) regardless of where the counter was.
  assign cur_x = start_i ? '0 : x_q;
  assign cur_y = start_i ? '0 : y_q;
  assign x_end = (cur_x == XW'(SIZE_X - 1));
  assign y_end = (cur_y == YW'(SIZE_Y - 1));

  assign border_o = (cur_x == '0) || x_end || (cur_y == '0) || y_end;
  assign last_o   = x_end && y_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (step_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/sobel_threshold.sv
// Sobel magnitude threshold stage: border blanking, 8-bit scaling, binary
// edge map and per-frame edge count. Define SOBEL_THR_GRAY_EN to output the
// scaled magnitude on edge pixels instead of 10'h3FF.
module sobel_threshold
  import sobel_pkg::*;
#(
  parameter int SIZE_X = DEFAULT_SIZE_X,
  parameter int SIZE_Y = DEFAULT_SIZE_Y,
  parameter int SHIFT  = 2,
  parameter int CNT_W  = 20
) (
  input  logic            clock,
  input  logic            reset_n,
  sobel_threshold_if.slave bus
);

  state_e             state_q;
  logic               start, process, border, last;
  logic [PIX_W-1:0]   shifted;
  logic [MAG_W-1:0]   mag;

  logic               s1_valid_q, s1_border_q, s1_first_q, s1_last_q;
  logic [MAG_W-1:0]   s1_mag_q, s1_thr_q;

  logic               is_edge;
  logic [PIX_W-1:0]   edge_pix;
  logic [CNT_W-1:0]   cnt_base, cnt_d, run_cnt_q, edge_count_q;
  logic [PIX_W-1:0]   pout_q;
  logic               pout_valid_q, frame_done_q;

  // fsync restarts a frame from any state; plain beats only count while ACTIVE.
  assign start   = bus.control && bus.fsync;
  assign process = bus.control && (bus.fsync || (state_q == ACTIVE));

  sobel_pix_counter #(
    .SIZE_X (SIZE_X),
    .SIZE_Y (SIZE_Y)
  ) u_pix_counter (
    .clk      (clock),
    .rst_n    (reset_n),
    .start_i  (start),
    .step_i   (process),
    .border_o (border),
    .last_o   (last)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (process && last) begin
      state_q <= DONE;
    end else if (start) begin
      state_q <= ACTIVE;
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end
  end

  assign shifted = bus.pin >> SHIFT;
  assign mag     = sat_mag(shifted);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_border_q <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_thr_q    <= '0;
    end else begin
      s1_valid_q <= process;
      if (process) begin
        s1_border_q <= border;
        s1_first_q  <= start;
        s1_last_q   <= last;
        s1_mag_q    <= mag;
        s1_thr_q    <= bus.threshold;
      end
    end
  end

  assign is_edge = s1_valid_q && !s1_border_q && (s1_mag_q >= s1_thr_q);

`ifdef SOBEL_THR_GRAY_EN
  assign edge_pix = {s1_mag_q, 2'b00};
`else
  assign edge_pix = {PIX_W{1'b1}};
`endif

  // The first beat of a frame restarts the count, so beats of an aborted
  // frame still in flight cannot leak into the new one.
  assign cnt_base = s1_first_q ? '0 : run_cnt_q;
  assign cnt_d    = (is_edge && (cnt_base != {CNT_W{1'b1}})) ? cnt_base + CNT_W'(1) : cnt_base;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      run_cnt_q    <= '0;
      edge_count_q <= '0;
    end else begin
      pout_q       <= is_edge ? edge_pix : '0;
      pout_valid_q <= s1_valid_q;
      frame_done_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        run_cnt_q <= cnt_d;
      end
      if (s1_valid_q && s1_last_q) begin
        edge_count_q <= cnt_d;
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.edge_count = edge_count_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_threshold.sv
// Directed scoreboard bench for sobel_threshold on an 8x4 image; runs a
// SHIFT=2 and a SHIFT=0 instance side by side on identical stimulus.
module tb_sobel_threshold;
  import sobel_pkg::*;

  localparam int SX = 8;
  localparam int SY = 4;
  localparam int CW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_threshold_if #(.CNT_W(CW)) bus2 ();
  sobel_threshold_if #(.CNT_W(CW)) bus0 ();

  sobel_threshold #(.SIZE_X(SX), .SIZE_Y(SY), .SHIFT(2), .CNT_W(CW)) u_dut2 (
    .clock(clk), .reset_n(rst_n), .bus(bus2));
  sobel_threshold #(.SIZE_X(SX), .SIZE_Y(SY), .SHIFT(0), .CNT_W(CW)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .bus(bus0));

  typedef struct {
    logic [9:0]    p2;
    logic [9:0]    p0;
    logic          fd;
    logic [CW-1:0] c2;
    logic [CW-1:0] c0;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            m_state, mx, my;
  logic [CW-1:0] mcnt2, mcnt0, ec2, ec0;
  logic          pv1, pv2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_mag(input logic [9:0] pin, input int sh);
    int s;
    s = int'(pin) >> sh;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  function automatic logic [9:0] model_pix(input logic e, input logic [7:0] m);
`ifdef SOBEL_THR_GRAY_EN
    return e ? {m, 2'b00} : 10'h000;
`else
    return e ? 10'h3FF : 10'h000;
`endif
  endfunction

  task automatic drive(input logic ctl, input logic fs, input logic [9:0] pin, input logic [7:0] thr);
    bus2.control = ctl; bus2.fsync = fs; bus2.pin = pin; bus2.threshold = thr;
    bus0.control = ctl; bus0.fsync = fs; bus0.pin = pin; bus0.threshold = thr;
  endtask

  // One clock: compare what the DUTs present now, then drive the next beat
  // and push its expected outcome.
  task automatic step(input logic ctl, input logic fs, input logic [9:0] pin, input logic [7:0] thr);
    exp_t       e;
    logic       acc, bd, last, e2, e0;
    logic [7:0] m2, m0;
    @(negedge clk);
    check("pout_valid", 32'(bus2.pout_valid), 32'(pv2));
    check("pout_valid_s0", 32'(bus0.pout_valid), 32'(pv2));
    if (pv2) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pout", 32'(bus2.pout), 32'(e.p2));
        check("pout_s0", 32'(bus0.pout), 32'(e.p0));
        check("frame_done", 32'(bus2.frame_done), 32'(e.fd));
        check("frame_done_s0", 32'(bus0.frame_done), 32'(e.fd));
        if (e.fd) begin
          ec2 = e.c2;
          ec0 = e.c0;
        end
      end
    end else begin
      check("frame_done_idle", 32'(bus2.frame_done), 32'd0);
      check("frame_done_idle_s0", 32'(bus0.frame_done), 32'd0);
    end
    check("edge_count", 32'(bus2.edge_count), 32'(ec2));
    check("edge_count_s0", 32'(bus0.edge_count), 32'(ec0));

    drive(ctl, fs, pin, thr);
    acc = ctl && (fs || (m_state == 1));
    if (acc) begin
      if (fs) begin
        mx = 0; my = 0; mcnt2 = '0; mcnt0 = '0;
      end
      bd   = (mx == 0) || (mx == SX-1) || (my == 0) || (my == SY-1);
      last = (mx == SX-1) && (my == SY-1);
      m2 = model_mag(pin, 2);
      m0 = model_mag(pin, 0);
      e2 = !bd && (m2 >= thr);
      e0 = !bd && (m0 >= thr);
      if (e2 && mcnt2 != '1) mcnt2++;
      if (e0 && mcnt0 != '1) mcnt0++;
      e.p2 = model_pix(e2, m2);
      e.p0 = model_pix(e0, m0);
      e.fd = last;
      e.c2 = mcnt2;
      e.c0 = mcnt0;
      sb.push_back(e);
      if (mx == SX-1) begin
        mx = 0;
        my = (my == SY-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      m_state = last ? 2 : 1;
    end else if (m_state == 2) begin
      m_state = 0;
    end
    pv2 = pv1;
    pv1 = acc;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 10'h3FF, 8'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_pout", 32'(bus2.pout), 32'd0);
      check("rst_pout_valid", 32'(bus2.pout_valid), 32'd0);
      check("rst_edge_count", 32'(bus2.edge_count), 32'd0);
      check("rst_frame_done", 32'(bus2.frame_done), 32'd0);
      check("rst_edge_count_s0", 32'(bus0.edge_count), 32'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10'h000, 8'd0);
    m_state = 0; mx = 0; my = 0;
    mcnt2 = '0; mcnt0 = '0; ec2 = '0; ec0 = '0;
    pv1 = 1'b0; pv2 = 1'b0;
    sb.delete();
  endtask

  task automatic flush();
    repeat (4) step(1'b0, 1'b0, 10'h000, 8'd0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 10'h3FF, 8'd0);
    do_reset(3);

    // Beats without fsync while IDLE are ignored.
    repeat (3) step(1'b1, 1'b0, 10'h3FF, 8'd0);

    // Uniform frame: 12 interior edges.
    for (int i = 0; i < SX*SY; i++) step(1'b1, i == 0, 10'd400, 8'd100);
    flush();
    check("uniform_count", 32'(bus2.edge_count), 32'd12);

    // Threshold boundary: mag8 99 vs 100 by column parity.
    for (int i = 0; i < SX*SY; i++)
      step(1'b1, i == 0, ((i % SX) % 2 == 0) ? 10'd400 : 10'd396, 8'd100);
    flush();
    check("boundary_count", 32'(bus2.edge_count), 32'd6);
    check("boundary_count_s0", 32'(bus0.edge_count), 32'd12);

    // Saturation at threshold 255.
    for (int i = 0; i < SX*SY; i++) step(1'b1, i == 0, 10'h3FF, 8'd255);
    flush();
    check("sat_count", 32'(bus2.edge_count), 32'd12);
    check("sat_count_s0", 32'(bus0.edge_count), 32'd12);

    // Threshold 0 with zero magnitude: every interior pixel is an edge.
    for (int i = 0; i < SX*SY; i++) step(1'b1, i == 0, 10'd0, 8'd0);
    flush();
    check("thr0_count", 32'(bus2.edge_count), 32'd12);

    // Back-to-back frames: second fsync lands in the DONE cycle, then a
    // stray beat in DONE after the second frame is ignored.
    for (int i = 0; i < SX*SY; i++) step(1'b1, i == 0, 10'd400, 8'd100);
    for (int i = 0; i < SX*SY; i++) step(1'b1, i == 0, 10'(i * 20), 8'd100);
    step(1'b1, 1'b0, 10'h3FF, 8'd0);
    flush();
    check("b2b_count", 32'(bus2.edge_count), 32'd3);
    check("b2b_count_s0", 32'(bus0.edge_count), 32'd12);

    // Control toggling every cycle.
    for (int i = 0; i < 2*SX*SY; i++) step(i % 2 == 0, i == 0, 10'd400, 8'd100);
    flush();
    check("stall_count", 32'(bus2.edge_count), 32'd12);

    // Abort at beat 10, then a full restarted frame.
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, 10'd400, 8'd0);
    for (int i = 0; i < SX*SY; i++)
      step(1'b1, i == 0, 10'd200, (i < 16) ? 8'd0 : 8'd100);
    flush();
    check("abort_count", 32'(bus2.edge_count), 32'd6);
    check("abort_count_s0", 32'(bus0.edge_count), 32'd12);

    // Reset mid-frame discards it.
    for (int i = 0; i < 12; i++) step(1'b1, i == 0, 10'd400, 8'd100);
    do_reset(2);
    flush();
    check("post_reset_count", 32'(bus2.edge_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_threshold.md
Name: sobel_threshold

Overview:
- Downstream stage of the Sobel filter: consumes its 10-bit gradient-magnitude stream, one beat per `control`-qualified clock.
- Tracks window-centre pixel coordinates from a frame-sync pulse and blanks the 1-pixel image border, where the 3x3 window is invalid.
- Scales and saturates the magnitude to 8 bits, compares it to a runtime threshold, and emits a binary edge map on the same 10-bit pixel bus format.
- Counts edge pixels per frame and reports the count with a one-cycle frame-done pulse.

Parameters:
- SIZE_X, 640, image width in pixels.
- SIZE_Y, 480, image height in pixels.
- SHIFT, 2, right-shift applied to the magnitude before 8-bit saturation (0..2).
- CNT_W, 20, width of edge_count; must satisfy 2^CNT_W > SIZE_X*SIZE_Y.

Ports:
- clock  in  1  master clock.
- reset_n  in  1  synchronous reset, active-low.
- control  in  1  beat valid; pin is sampled only when high.
- fsync  in  1  qualified by control; marks the beat carrying window-centre pixel (0,0).
- pin  in  10  unsigned gradient magnitude from the Sobel stage.
- threshold  in  8  edge threshold; sampled at each accepted beat.
- pout  out  10  pixel out; 10'h3FF = edge, 10'h000 = no edge/border.
- pout_valid  out  1  pout qualifier.
- edge_count  out  CNT_W  edge pixels in the last completed frame.
- frame_done  out  1  one-cycle pulse when edge_count is updated.

Behaviour:
- Reset (clock edge with reset_n=0):
  - pout=0, pout_valid=0, edge_count=0, frame_done=0.
  - Internal x, y and running count cleared; state IDLE.
  - Reset mid-frame discards the frame with no frame_done.
- FSM states IDLE, ACTIVE, DONE:
  - IDLE: beats without fsync are ignored (pout_valid stays 0). control&&fsync -> ACTIVE; that beat is pixel (0,0) and is processed.
  - ACTIVE: each control beat is processed at current (x,y), then x++. When x==SIZE_X-1, x wraps to 0 and y++. The beat at (SIZE_X-1, SIZE_Y-1) -> DONE.
  - DONE: lasts exactly one cycle, then IDLE. A control beat arriving in DONE is ignored unless fsync is set, in which case it starts the next frame (DONE -> ACTIVE).
  - fsync in ACTIVE: restart at (0,0), running count cleared, aborted frame produces no frame_done, edge_count holds its old value.
- Datapath, 2-stage pipeline:
  - Stage 1 registers: s = pin >> SHIFT; mag8 = (s > 255) ? 255 : s[7:0]; border = (x==0 || x==SIZE_X-1 || y==0 || y==SIZE_Y-1); and threshold.
  - Stage 2: edge = !border && (mag8 >= threshold); pout = edge ? 10'h3FF : 0.
  - pout_valid is asserted exactly 2 clocks after an accepted beat. Output beats keep input order with no gaps added or removed.
  - threshold=0: every non-border pixel is an edge. Border pixels are never edges.
- Counting and frame completion:
  - Running count increments on each stage-2 edge.
  - frame_done pulses in the same cycle as pout_valid for the frame's last pixel; edge_count then equals the running count including that pixel.
  - The running count clears for the next frame; it saturates at 2^CNT_W-1.
- Stall: control low freezes x, y and FSM, and inserts bubbles in the pipeline (pout_valid=0 two cycles later).

Optional Feature:
- SOBEL_THR_GRAY_EN:
  - Defined: edge pixels output the scaled magnitude, pout = {mag8, 2'b00}; non-edge and border pixels output 0. Counting is unchanged.
  - Undefined: binary output as above.

Decomposition:
- Shared package sobel_pkg holds the FSM state typedef (IDLE/ACTIVE/DONE), the default SIZE_X/SIZE_Y constants, and the pixel-width constants PIX_W=10 and MAG_W=8.
- One natural sub-module, sobel_pix_counter: the x/y coordinate counter with wrap, last-pixel and border flags.
- Threshold datapath and FSM stay in the top.

Test Plan (SIZE_X=8, SIZE_Y=4, SHIFT=2 unless noted):
- Reset: hold reset_n=0 for 3 cycles while driving control=1, pin=10'h3FF -> pout=0, pout_valid=0, edge_count=0, frame_done=0 throughout.
- Uniform frame: fsync on beat 0, 32 beats of pin=400 (mag8=100), threshold=100 -> 12 interior pouts = 3FF, 20 border pouts = 0; frame_done 2 cycles after the last beat; edge_count=12.
- Threshold boundary: interior pixels alternate pin=396/400 (mag8=99/100), threshold=100 -> only the pin=400 pixels give 3FF; edge_count=6.
- Saturation with SHIFT=0: pin=1023, threshold=255 -> mag8 saturates to 255; all 12 interior pixels are edges.
- Stalls and abort:
  - control toggled 1/0 every cycle -> pout_valid pattern mirrors control delayed by 2; counts unchanged.
  - fsync reasserted at beat 10 -> no frame_done for the first frame; the next frame_done reports the restarted frame's count.
- SOBEL_THR_GRAY_EN build: pin=400, threshold=50 -> interior pout=10'd400, border pout=0.
